cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits between the cache controller and physical memory, directly upstream of the cache data array.
- Converts one 256-bit cacheline read or write into a 4-beat x 64-bit memory burst.
- On reads, the assembled line_o feeds the data array's 256-bit datain, paired with a full 32-bit byte write-enable. On writes, it serialises an evicted dirty line.
- Holds one outstanding transaction at a time.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BEAT_W, 64, memory burst beat width in bits; beats = LINE_W/BEAT_W (4).
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- address_i  in  32  cache request byte address
- read_i  in  1  cache line-fill request
- write_i  in  1  cache line-writeback request
- line_i  in  LINE_W  line to write back
- line_o  out  LINE_W  assembled fill line
- resp_o  out  1  one-cycle completion pulse
- address_o  out  32  line-aligned memory address
- read_o  out  1  memory burst read request
- write_o  out  1  memory burst write request
- burst_o  out  BEAT_W  write beat data
- burst_i  in  BEAT_W  read beat data
- resp_i  in  1  memory beat valid/accept
- error_o  out  1  timeout flag (tied 0 when the feature is out)

Behaviour:
- Reset values:
  - state IDLE
  - read_o, write_o, resp_o, error_o = 0
  - line_o, burst_o = 0
  - address_o = 0
  - beat counter = 0
- States: IDLE, RD, WR, DONE.
- IDLE: requests are sampled only here.
  - write_i wins if read_i and write_i are both high.
  - On accept, latch address_i with bits [4:0] forced to 0 into address_o.
  - On a write, latch line_i into an internal buffer.
  - Go to WR or RD the next cycle.
- RD:
  - read_o is high throughout the state.
  - Each cycle with resp_i=1 stores burst_i into line_o[64*k +: 64], then increments k.
  - Cycles with resp_i=0 are stalls and may occur between beats.
  - After beat 3 is stored: read_o drops, counter wraps to 0, go to DONE.
- WR:
  - write_o is high; burst_o = buffer[64*k +: 64].
  - k advances on resp_i. After beat 3 is accepted: write_o drops, go to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle, then return to IDLE.
  - A new request is not accepted until the cycle after DONE.
- Latency: read/write complete at 1 (request) + 4 beats + 1 (DONE). Minimum from request sample to resp_o is 6 cycles.
- line_o holds its value from DONE until the first beat of the next read. Writes never modify line_o.
- address_o is stable for the whole transaction.
- read_i/write_i/line_i changes after acceptance are ignored.
- resp_i in IDLE or DONE is ignored.
- rst in any state: immediately return to IDLE with reset values.
  - A partially assembled line is discarded; line_o is cleared to 0.

Optional Feature:
- Macro CACHELINE_ADAPTOR_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter increments on every RD/WR cycle with resp_i=0 and clears on each resp_i.
  - When the counter reaches TIMEOUT: drop read_o/write_o, go to DONE, pulse resp_o, and set sticky error_o=1 until rst.
  - line_o contents after a timed-out read are undefined.
- Without the macro: no counter, error_o is constant 0, and a stalled memory hangs the adaptor indefinitely.

Decomposition:
- Shared cache package holds:
  - constants LINE_W, BEAT_W, NUM_BEATS=4, OFFSET_BITS=5
  - adaptor state enum type
  - a line-aligned address function
- One sub-module is natural: beat_counter (2-bit wrap counter with enable and synchronous clear), reused by the read and write paths.

Test Plan:
- Read, back-to-back beats: read_i with address 0x0000_1234; memory returns 0x11.., 0x22.., 0x33.., 0x44.. on consecutive resp_i.
  - Expect address_o=0x0000_1220.
  - Expect line_o={0x44..,0x33..,0x22..,0x11..}.
  - Expect a single resp_o pulse at cycle 6.
- Read with stalls: resp_i gaps of 2 cycles between each beat.
  - Expect the same line_o, resp_o at cycle 12, and read_o high throughout.
- Write: write_i with line_i=256'h0123...CDEF; resp_i held high.
  - Expect burst_o sequence line_i[63:0], [127:64], [191:128], [255:192] and resp_o at cycle 6.
  - Expect line_o unchanged.
- Simultaneous read_i and write_i: expect a write transaction only, and read_o never asserts.
- rst after 2 read beats: next cycle, all outputs are at reset values.
  - A subsequent full read completes correctly with the counter starting at beat 0.
- With CACHELINE_ADAPTOR_TIMEOUT_EN and TIMEOUT=16: a read where memory never responds.
  - Expect read_o to drop, resp_o to pulse, and error_o to stay at 1 until rst.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared cacheline constants, adaptor state type and line-alignment helper.
package cacheline_adaptor_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int NUM_BEATS   = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side bus of the cacheline adaptor.
// master: the environment (cache controller + memory); slave: the adaptor.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic              resp_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i;
  logic              resp_i;
  logic              error_o;

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o, error_o
  );

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o, error_o
  );

endinterface

// File: rtl/cacheline_adaptor_beat_counter.sv
// Two-bit beat index with enable and synchronous clear; wraps after the last beat.
module cacheline_adaptor_beat_counter
  import cacheline_adaptor_pkg::*;
(
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [1:0] o_cnt,
  output logic       o_last
);

  logic [1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)     r_cnt <= 2'd0;
    else if (i_en) r_cnt <= r_cnt + 2'd1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == 2'(NUM_BEATS - 1));

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line read/write into a 4 x 64-bit memory burst.
// Optional stall watchdog: define CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  cacheline_adaptor_if.slave bus
);

  state_e            r_state;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_buf;
  logic [LINE_W-1:0] r_line;
  logic [BEAT_W-1:0] r_burst;
  logic              r_read;
  logic              r_write;
  logic              r_resp;

  logic [1:0]        w_beat;
  logic [1:0]        w_next_beat;
  logic              w_last;
  logic              w_busy;
  logic              w_accept;
  logic              w_beat_en;
  logic              w_beat_clr;
  logic              w_timeout;

  assign w_busy      = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_accept    = (r_state == ST_IDLE) && (bus.read_i || bus.write_i);
  assign w_beat_en   = w_busy && bus.resp_i;
  assign w_beat_clr  = rst || w_accept || w_timeout;
  assign w_next_beat = w_beat + 2'd1;

  cacheline_adaptor_beat_counter u_beat_counter (
    .clk    (clk),
    .i_clr  (w_beat_clr),
    .i_en   (w_beat_en),
    .o_cnt  (w_beat),
    .o_last (w_last)
  );

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] r_stall;
  logic       r_error;

  // Counts consecutive stall cycles of the current burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 8'd0;
      r_error <= 1'b0;
    end else begin
      if (!w_busy || bus.resp_i) r_stall <= 8'd0;
      else                       r_stall <= r_stall + 8'd1;
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign w_timeout   = w_busy && !bus.resp_i && (r_stall == 8'(TIMEOUT - 1));
  assign bus.error_o = r_error;
`else
  assign w_timeout   = 1'b0;
  // Always 0: TIMEOUT only matters when the watchdog is built in.
  assign bus.error_o = (TIMEOUT < 0);
`endif

  // Write data is captured once at acceptance; later line_i changes are ignored.
  always_ff @(posedge clk) begin
    if (w_accept && bus.write_i) r_buf <= bus.line_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'd0;
      r_line  <= '0;
      r_burst <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.write_i) begin
            r_state <= ST_WR;
            r_write <= 1'b1;
            r_addr  <= line_align(bus.address_i);
            r_burst <= bus.line_i[BEAT_W-1:0];
          end else if (bus.read_i) begin
            r_state <= ST_RD;
            r_read  <= 1'b1;
            r_addr  <= line_align(bus.address_i);
          end
        end
        ST_RD: begin
          if (w_timeout) begin
            r_state <= ST_DONE;
            r_read  <= 1'b0;
            r_resp  <= 1'b1;
          end else if (bus.resp_i) begin
            r_line[BEAT_W*w_beat +: BEAT_W] <= bus.burst_i;
            if (w_last) begin
              r_state <= ST_DONE;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (w_timeout) begin
            r_state <= ST_DONE;
            r_write <= 1'b0;
            r_resp  <= 1'b1;
          end else if (bus.resp_i) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
            end else begin
              r_burst <= r_buf[BEAT_W*w_next_beat +: BEAT_W];
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.address_o = r_addr;
  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.resp_o    = r_resp;
  assign bus.line_o    = r_line;
  assign bus.burst_o   = r_burst;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized and directed bench for cacheline_adaptor with a transaction-level model.
// Exercises the watchdog too when CACHELINE_ADAPTOR_TIMEOUT_EN is defined.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  cacheline_adaptor_if bus();

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TO = 16;
  cacheline_adaptor #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // ---------------- memory responder ----------------
  // gap_mode >= 0: fixed stall between beats; -1: random 0..3; -2: never respond
  int          gap_mode;
  logic        fixed_data;
  logic [63:0] mem_data [4];
  int          r_idx;
  int          r_gap;
  logic        r_was;

  function automatic int pick_gap(input bit first);
    if (gap_mode == -2) return -1;
    if (gap_mode == -1) return int'($urandom_range(0, 3));
    return first ? 0 : gap_mode;
  endfunction

  initial begin
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    r_was = 1'b0;
    r_idx = 0;
    r_gap = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!(bus.read_o || bus.write_o)) begin
        r_was       = 1'b0;
        bus.resp_i  = 1'($urandom_range(0, 1));
        bus.burst_i = {$urandom, $urandom};
      end else begin
        if (!r_was) begin
          r_idx = 0;
          r_gap = pick_gap(1'b1);
        end else if (bus.resp_i) begin
          r_idx++;
          r_gap = pick_gap(1'b0);
        end
        r_was = 1'b1;
        if (r_gap == 0) begin
          bus.resp_i  = 1'b1;
          bus.burst_i = fixed_data ? mem_data[r_idx & 3] : {$urandom, $urandom};
        end else begin
          bus.resp_i  = 1'b0;
          bus.burst_i = {$urandom, $urandom};
          if (r_gap > 0) r_gap--;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic         m_valid, m_act, m_wr, m_done, m_err, m_line_ok;
  int           m_beats, m_stall;
  logic [31:0]  m_addr;
  logic [255:0] m_line, m_buf;

  initial begin
    m_valid = 0; m_act = 0; m_wr = 0; m_done = 0; m_err = 0; m_line_ok = 1;
    m_beats = 0; m_stall = 0; m_addr = '0; m_line = '0; m_buf = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act = 0; m_done = 0; m_err = 0; m_line_ok = 1;
        m_beats = 0; m_stall = 0; m_addr = '0; m_line = '0;
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_act) begin
        if (bus.read_i || bus.write_i) begin
          m_act   = 1;
          m_wr    = bus.write_i;
          m_addr  = bus.address_i & 32'hFFFF_FFE0;
          m_buf   = bus.line_i;
          m_beats = 0;
          m_stall = 0;
        end
      end else if (bus.resp_i) begin
        if (!m_wr) m_line[m_beats*64 +: 64] = bus.burst_i;
        m_beats++;
        m_stall = 0;
        if (m_beats == 4) begin
          m_act  = 0;
          m_done = 1;
        end
      end else begin
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          m_act = 0; m_done = 1; m_err = 1; m_line_ok = 0;
        end
`endif
      end
      m_valid = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("read_o",    256'(bus.read_o),    256'(m_act && !m_wr));
        chk("write_o",   256'(bus.write_o),   256'(m_act && m_wr));
        chk("resp_o",    256'(bus.resp_o),    256'(m_done));
        chk("address_o", 256'(bus.address_o), 256'(m_addr));
        chk("error_o",   256'(bus.error_o),   256'(m_err));
        if (m_line_ok) chk("line_o", bus.line_o, m_line);
        if (m_act && m_wr) chk("burst_o", 256'(bus.burst_o), 256'(m_buf[m_beats*64 +: 64]));
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic        saw_read, saw_write, read_gap;
  logic [63:0] wbeats [4];
  int          nb;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [255:0] l, output int cyc, output bit ok);
    bus.read_i = rd; bus.write_i = wr; bus.address_i = a; bus.line_i = l;
    saw_read = 0; saw_write = 0; read_gap = 0; nb = 0;
    cyc = 1; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (i == 0) begin
        bus.read_i = 0; bus.write_i = 0; bus.address_i = ~a; bus.line_i = ~l;
      end
      cyc++;
      if (bus.read_o) saw_read = 1;
      if (!bus.read_o && !bus.resp_o && rd && !wr) read_gap = 1;
      if (bus.write_o) begin
        saw_write = 1;
        if (bus.resp_i && nb < 4) begin
          wbeats[nb] = bus.burst_o;
          nb++;
        end
      end
      if (bus.resp_o) ok = 1;
    end
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL txn_complete: got no resp_o, want resp_o within 200 cycles");
  endtask

  localparam logic [255:0] RD_LINE = {64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] WR_LINE = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

  initial begin
    int cyc;
    bit ok;
    logic [255:0] rl;
    n_total = 0; n_pass = 0;
    rst = 1;
    bus.read_i = 0; bus.write_i = 0; bus.address_i = '0; bus.line_i = '0;
    gap_mode = 0; fixed_data = 1;
    mem_data[0] = 64'h1111111111111111; mem_data[1] = 64'h2222222222222222;
    mem_data[2] = 64'h3333333333333333; mem_data[3] = 64'h4444444444444444;
    tick(); tick();
    chk("rst_read_o",  256'(bus.read_o),    256'(0));
    chk("rst_write_o", 256'(bus.write_o),   256'(0));
    chk("rst_resp_o",  256'(bus.resp_o),    256'(0));
    chk("rst_error_o", 256'(bus.error_o),   256'(0));
    chk("rst_addr_o",  256'(bus.address_o), 256'(0));
    chk("rst_line_o",  bus.line_o,          256'(0));
    chk("rst_burst_o", 256'(bus.burst_o),   256'(0));
    rst = 0;
    tick();

    // back-to-back read
    do_txn(1, 0, 32'h0000_1234, '0, cyc, ok);
    chk("rd_latency", 256'(cyc), 256'(6));
    chk("rd_addr",    256'(bus.address_o), 256'(32'h0000_1220));
    chk("rd_line",    bus.line_o, RD_LINE);
    tick();
    chk("rd_single_pulse", 256'(bus.resp_o), 256'(0));

    // read with 2-cycle gaps between beats
    gap_mode = 2;
    do_txn(1, 0, 32'h0000_1234, '0, cyc, ok);
    chk("rd_stall_latency", 256'(cyc), 256'(12));
    chk("rd_stall_line",    bus.line_o, RD_LINE);
    chk("rd_stall_read_hi", 256'(read_gap), 256'(0));
    tick();

    // write with resp_i held
    gap_mode = 0;
    do_txn(0, 1, 32'h0000_8041, WR_LINE, cyc, ok);
    chk("wr_latency", 256'(cyc), 256'(6));
    chk("wr_beat0", 256'(wbeats[0]), 256'(64'h8796A5B4C3D2E1F0));
    chk("wr_beat1", 256'(wbeats[1]), 256'(64'h0F1E2D3C4B5A6978));
    chk("wr_beat2", 256'(wbeats[2]), 256'(64'hFEDCBA9876543210));
    chk("wr_beat3", 256'(wbeats[3]), 256'(64'h0123456789ABCDEF));
    chk("wr_line_kept", bus.line_o, RD_LINE);
    tick();

    // simultaneous read+write: write wins
    do_txn(1, 1, 32'hABCD_EF7F, ~WR_LINE, cyc, ok);
    chk("both_no_read",  256'(saw_read),  256'(0));
    chk("both_write",    256'(saw_write), 256'(1));
    chk("both_addr",     256'(bus.address_o), 256'(32'hABCD_EF60));
    chk("both_beat0",    256'(wbeats[0]), 256'(64'h78695A4B3C2D1E0F));
    tick();

    // reset after two read beats
    bus.read_i = 1; bus.address_i = 32'h0000_1234;
    tick();
    bus.read_i = 0;
    tick(); tick();
    rst = 1;
    tick();
    chk("mid_rst_read_o", 256'(bus.read_o),    256'(0));
    chk("mid_rst_resp_o", 256'(bus.resp_o),    256'(0));
    chk("mid_rst_addr_o", 256'(bus.address_o), 256'(0));
    chk("mid_rst_line_o", bus.line_o,          256'(0));
    chk("mid_rst_burst",  256'(bus.burst_o),   256'(0));
    rst = 0;
    tick();
    do_txn(1, 0, 32'h0000_1234, '0, cyc, ok);
    chk("post_rst_latency", 256'(cyc), 256'(6));
    chk("post_rst_line",    bus.line_o, RD_LINE);
    tick();

    // randomized traffic with occasional resets
    gap_mode = -1; fixed_data = 0;
    for (int i = 0; i < 1500; i++) begin
      bus.read_i  = ($urandom_range(0, 3) == 0);
      bus.write_i = ($urandom_range(0, 4) == 0);
      bus.address_i = $urandom;
      for (int w = 0; w < 8; w++) rl[w*32 +: 32] = $urandom;
      bus.line_i = rl;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0; bus.read_i = 0; bus.write_i = 0;
    repeat (20) tick();

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // memory never answers
    gap_mode = -2;
    do_txn(1, 0, 32'h0000_2000, '0, cyc, ok);
    chk("to_read_dropped", 256'(bus.read_o),  256'(0));
    chk("to_error",        256'(bus.error_o), 256'(1));
    repeat (10) tick();
    chk("to_error_sticky", 256'(bus.error_o), 256'(1));
    rst = 1;
    tick();
    rst = 0;
    chk("to_error_cleared", 256'(bus.error_o), 256'(0));
    repeat (3) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
